timer_clk_ctrl: RTL and testbench

Count-enable generator for the 8-bit APB timer, sitting directly upstream of the counter. It turns pclk into a one-cycle `cnt_en` strobe at the rate selected by the TCR clock-select field. Sources are pclk divided by 2, 4, 8 or 16, or, optionally, rising edges of an external clock pin. The counter advances (up or down) only in cycles where `cnt_en` is high, so a timer pause gates this block's output rather than the counter itself.

---
 rtl/timer_clk_ctrl.sv | 160 ++++++++++++++++
 tb/tb_timer_clk_ctrl.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_clk_ctrl.sv
// timer_clk_ctrl
// -----------------------------------------------------------------------------
// Count-enable generator for the 8-bit APB timer. It sits directly upstream of
// the counter and turns pclk into a single-cycle count strobe at the rate chosen
// by the TCR clock-select field. A free-running prescaler supplies pclk/2, /4,
// /8 and /16 ticks. When TIMER_EXT_CLK_EN is defined, rising edges of an
// asynchronous external pin can also be selected. A timer pause gates the
// strobe here, so the counter itself never needs a separate hold input.
//
// Build option:
//   TIMER_EXT_CLK_EN  defined   : ext_clk synchronizer and edge detector are
//                                 built, and cks = 4 selects external edges.
//                     undefined : ext_clk is ignored, and cks = 4 behaves like
//                                 a reserved select (no strobes).
//   The port list is the same in both builds.
//
// Parameters:
//   PRE_W    prescaler width (must be >= 4 so that pclk/16 is reachable)
//
// Ports:
//   pclk     in   1      only clock; all state samples its rising edge
//   presetn  in   1      asynchronous active-low reset
//   tmr_en   in   1      timer enable from TCR (0 = paused)
//   cks      in   3      clock select: 0..3 = pclk/2,/4,/8,/16
//                        4 = external rising edge, 5..7 = reserved
//   ext_clk  in   1      external clock pin, asynchronous to pclk
//   cnt_en   out  1      registered one-pclk count strobe to the counter
//   pre_cnt  out  PRE_W  current prescaler value (debug visibility)
// -----------------------------------------------------------------------------
module timer_clk_ctrl #(
  parameter int unsigned PRE_W = 4
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             tmr_en,
  input  logic [2:0]       cks,
  input  logic             ext_clk,
  output logic             cnt_en,
  output logic [PRE_W-1:0] pre_cnt
);

  // Clock-select encodings
  localparam logic [2:0] CksDiv2  = 3'd0;
  localparam logic [2:0] CksDiv4  = 3'd1;
  localparam logic [2:0] CksDiv8  = 3'd2;
  localparam logic [2:0] CksDiv16 = 3'd3;
  localparam logic [2:0] CksExt   = 3'd4;

  // ---------------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------------
  // Free-running counter. It deliberately ignores tmr_en and cks, so pausing or
  // reselecting the source never shifts the divider phase.
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;

  always_comb begin
    pre_cnt_d = pre_cnt_q + PRE_W'(1);
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Internal divider ticks
  // ---------------------------------------------------------------------------
  // For select k, the tick fires when the low k+1 prescaler bits are all ones.
  // This gives exactly one single-cycle tick per 2^(k+1) pclk cycles.
  logic tick_div2, tick_div4, tick_div8, tick_div16;

  always_comb begin
    tick_div2  = pre_cnt_q[0];
    tick_div4  = &pre_cnt_q[1:0];
    tick_div8  = &pre_cnt_q[2:0];
    tick_div16 = &pre_cnt_q[3:0];
  end

  // ---------------------------------------------------------------------------
  // External edge tick
  // ---------------------------------------------------------------------------
  logic tick_ext;

`ifdef TIMER_EXT_CLK_EN
  // s1/s2 form the two-flop synchronizer. s3 holds the previous synchronized
  // level, so s2 & ~s3 is high for exactly one cycle per ext_clk rising edge.
  logic ext_s1_q, ext_s2_q, ext_s3_q;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ext_s1_q <= 1'b0;
      ext_s2_q <= 1'b0;
      ext_s3_q <= 1'b0;
    end else begin
      ext_s1_q <= ext_clk;
      ext_s2_q <= ext_s1_q;
      ext_s3_q <= ext_s2_q;
    end
  end

  always_comb begin
    tick_ext = ext_s2_q & ~ext_s3_q;
  end
`else
  // No synchronizer in this build. The pin stays on the port list but drives
  // nothing.
  logic unused_ext_clk;

  always_comb begin
    unused_ext_clk = ext_clk;
    tick_ext       = 1'b0;
  end
`endif

  // ---------------------------------------------------------------------------
  // Source select
  // ---------------------------------------------------------------------------
  // Every source is already a single-cycle pulse, so changing cks can neither
  // stretch a strobe nor produce a double strobe. Reserved codes select nothing
  // and raise no error.
  logic tick;

  always_comb begin
    tick = 1'b0;
    case (cks)
      CksDiv2:  tick = tick_div2;
      CksDiv4:  tick = tick_div4;
      CksDiv8:  tick = tick_div8;
      CksDiv16: tick = tick_div16;
      CksExt:   tick = tick_ext;
      default:  tick = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output strobe
  // ---------------------------------------------------------------------------
  // tmr_en is sampled on the same edge as the tick. A tick that arrives while
  // the timer is paused is dropped, not queued.
  logic cnt_en_q, cnt_en_d;

  always_comb begin
    cnt_en_d = tmr_en & tick;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt_en_q <= 1'b0;
    end else begin
      cnt_en_q <= cnt_en_d;
    end
  end

  assign cnt_en  = cnt_en_q;
  assign pre_cnt = pre_cnt_q;

endmodule

// File: tb/tb_timer_clk_ctrl.sv
// Directed self-checking bench for timer_clk_ctrl. Each scenario task drives
// its stimulus and compares DUT outputs with hand-derived expectations.
// Outputs are sampled 1 time unit after each rising pclk edge.
module tb_timer_clk_ctrl;

  logic       pclk;
  logic       presetn;
  logic       tmr_en;
  logic [2:0] cks;
  logic       ext_clk;
  logic       cnt_en;
  logic [3:0] pre_cnt;

  int n_cmp;
  int n_fail;

  timer_clk_ctrl #(
    .PRE_W(4)
  ) dut (
    .pclk   (pclk),
    .presetn(presetn),
    .tmr_en (tmr_en),
    .cks    (cks),
    .ext_clk(ext_clk),
    .cnt_en (cnt_en),
    .pre_cnt(pre_cnt)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step;
    @(posedge pclk);
    #1;
  endtask

  // Hold reset for two edges, then release it just after an edge. The next
  // rising edge is edge 1 after release.
  task automatic do_reset;
    presetn = 1'b0;
    step();
    step();
    presetn = 1'b1;
  endtask

  // Reset: outputs stay 0 while reset is held; afterwards pre_cnt counts from 1
  // and cnt_en strobes on every even edge.
  task automatic test_reset;
    logic exp_en;
    tmr_en  = 1'b1;
    cks     = 3'd0;
    ext_clk = 1'b0;
    presetn = 1'b0;
    #2;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (cnt_en !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_cnt_en cycle %0d: got %b want 0", i, cnt_en);
      end
      n_cmp++;
      if (pre_cnt !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_pre_cnt cycle %0d: got %0d want 0", i, pre_cnt);
      end
    end
    presetn = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      exp_en = (i % 2 == 0);
      n_cmp++;
      if (pre_cnt !== 4'(i)) begin
        n_fail++;
        $display("FAIL post_reset_pre_cnt edge %0d: got %0d want %0d", i, pre_cnt, i);
      end
      n_cmp++;
      if (cnt_en !== exp_en) begin
        n_fail++;
        $display("FAIL post_reset_cnt_en edge %0d: got %b want %b", i, cnt_en, exp_en);
      end
    end
  endtask

  // Divide ratios: count strobes over 256 edges for each internal select.
  task automatic test_divide;
    int strobes, consec, phase_bad, first;
    logic prev;
    logic [3:0] mask;
    for (int k = 0; k < 4; k++) begin
      strobes   = 0;
      consec    = 0;
      phase_bad = 0;
      first     = 0;
      prev      = 1'b0;
      mask      = 4'((2 << k) - 1);
      tmr_en    = 1'b1;
      cks       = 3'(k);
      do_reset();
      for (int i = 1; i <= 256; i++) begin
        step();
        if (cnt_en === 1'b1) begin
          strobes++;
          if (first == 0) first = i;
          // A strobe follows the all-ones value, so the low bits have wrapped to 0.
          if ((pre_cnt & mask) != 4'd0) phase_bad++;
          if (prev) consec++;
        end
        prev = cnt_en;
      end
      n_cmp++;
      if (strobes != (128 >> k)) begin
        n_fail++;
        $display("FAIL div_count cks=%0d: got %0d want %0d", k, strobes, 128 >> k);
      end
      n_cmp++;
      if (first != (2 << k)) begin
        n_fail++;
        $display("FAIL div_first cks=%0d: got edge %0d want %0d", k, first, 2 << k);
      end
      n_cmp++;
      if (consec != 0) begin
        n_fail++;
        $display("FAIL div_width cks=%0d: got %0d back-to-back want 0", k, consec);
      end
      n_cmp++;
      if (phase_bad != 0) begin
        n_fail++;
        $display("FAIL div_phase cks=%0d: got %0d off-phase want 0", k, phase_bad);
      end
    end
  endtask

  // Pause and resume: ticks during the pause are dropped, and the phase is kept.
  task automatic test_pause;
    int run1, paused, run2, phase_bad;
    run1      = 0;
    paused    = 0;
    run2      = 0;
    phase_bad = 0;
    tmr_en    = 1'b1;
    cks       = 3'd0;
    do_reset();
    for (int i = 1; i <= 100; i++) begin
      step();
      if (cnt_en === 1'b1) run1++;
    end
    tmr_en = 1'b0;
    for (int i = 101; i <= 120; i++) begin
      step();
      if (cnt_en !== 1'b0) paused++;
    end
    tmr_en = 1'b1;
    for (int i = 121; i <= 532; i++) begin
      step();
      if (cnt_en === 1'b1) begin
        run2++;
        if (pre_cnt[0] !== 1'b0) phase_bad++;
      end
    end
    n_cmp++;
    if (run1 != 50) begin
      n_fail++;
      $display("FAIL pause_run1: got %0d strobes want 50", run1);
    end
    n_cmp++;
    if (paused != 0) begin
      n_fail++;
      $display("FAIL pause_quiet: got %0d strobes want 0", paused);
    end
    n_cmp++;
    if (run1 + run2 != 256) begin
      n_fail++;
      $display("FAIL pause_total: got %0d strobes want 256", run1 + run2);
    end
    n_cmp++;
    if (phase_bad != 0) begin
      n_fail++;
      $display("FAIL pause_phase: got %0d off-phase want 0", phase_bad);
    end
  endtask

  // tmr_en rising in a tick cycle gives a strobe; falling in a tick cycle does not.
  task automatic test_enable_edge;
    tmr_en = 1'b0;
    cks    = 3'd1;
    do_reset();
    step();
    step();
    step();
    tmr_en = 1'b1;                    // cycle where pre_cnt = 3 (tick)
    step();
    n_cmp++;
    if (cnt_en !== 1'b1) begin
      n_fail++;
      $display("FAIL en_rise_tick: got %b want 1", cnt_en);
    end
    step();
    step();
    step();
    tmr_en = 1'b0;                    // cycle where pre_cnt = 7 (tick)
    step();
    n_cmp++;
    if (cnt_en !== 1'b0) begin
      n_fail++;
      $display("FAIL en_fall_tick: got %b want 0", cnt_en);
    end
  endtask

  // Reselect mid-interval: the new source takes effect on the next evaluation.
  task automatic test_reselect;
    int early, first, consec, cnt16;
    logic prev;
    early  = 0;
    first  = 0;
    consec = 0;
    cnt16  = 0;
    prev   = 1'b0;
    tmr_en = 1'b1;
    cks    = 3'd3;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      step();
      if (cnt_en === 1'b1) early++;
    end
    cks = 3'd0;                       // pre_cnt = 5 here, so pclk/2 ticks now
    for (int i = 6; i <= 12; i++) begin
      step();
      if (cnt_en === 1'b1) begin
        if (first == 0) first = i;
        if (prev) consec++;
      end
      prev = cnt_en;
    end
    cks = 3'd3;                       // switch back while cnt_en is high at edge 12
    for (int i = 13; i <= 16; i++) begin
      step();
      if (cnt_en === 1'b1) begin
        cnt16++;
        n_cmp++;
        if (i != 16) begin
          n_fail++;
          $display("FAIL resel_back_edge: got strobe at edge %0d want 16", i);
        end
      end
    end
    n_cmp++;
    if (early != 0) begin
      n_fail++;
      $display("FAIL resel_early: got %0d strobes want 0", early);
    end
    n_cmp++;
    if (first != 6) begin
      n_fail++;
      $display("FAIL resel_first: got edge %0d want 6", first);
    end
    n_cmp++;
    if (consec != 0) begin
      n_fail++;
      $display("FAIL resel_consec: got %0d want 0", consec);
    end
    n_cmp++;
    if (cnt16 != 1) begin
      n_fail++;
      $display("FAIL resel_back_count: got %0d want 1", cnt16);
    end
  endtask

  // External source: 10 ext_clk periods of 10 pclk each.
  task automatic test_external;
    int strobes, late_bad, exp_strobes;
`ifdef TIMER_EXT_CLK_EN
    exp_strobes = 10;
`else
    exp_strobes = 0;
`endif
    strobes  = 0;
    late_bad = 0;
    ext_clk  = 1'b0;
    tmr_en   = 1'b1;
    cks      = 3'd4;
    do_reset();
    step();
    step();
    step();
    for (int p = 0; p < 10; p++) begin
      #3 ext_clk = 1'b1;              // mid-cycle, asynchronous to pclk
      for (int i = 1; i <= 10; i++) begin
        step();
        if (cnt_en === 1'b1) begin
          strobes++;
          if (i < 3 || i > 4) late_bad++;
        end
        if (i == 5) begin
          #3 ext_clk = 1'b0;
        end
      end
    end
    n_cmp++;
    if (strobes != exp_strobes) begin
      n_fail++;
      $display("FAIL ext_count: got %0d strobes want %0d", strobes, exp_strobes);
    end
    n_cmp++;
    if (late_bad != 0) begin
      n_fail++;
      $display("FAIL ext_latency: got %0d out-of-window strobes want 0", late_bad);
    end
  endtask

  // Reserved selects never strobe, and the prescaler keeps wrapping.
  task automatic test_reserved;
    int strobes, pre_bad;
    logic [2:0] sel [3];
    sel[0] = 3'd6;
    sel[1] = 3'd5;
    sel[2] = 3'd7;
    for (int s = 0; s < 3; s++) begin
      strobes = 0;
      pre_bad = 0;
      tmr_en  = 1'b1;
      cks     = sel[s];
      do_reset();
      for (int i = 1; i <= 64; i++) begin
        step();
        if (cnt_en === 1'b1) strobes++;
        if (pre_cnt !== 4'(i % 16)) pre_bad++;
      end
      n_cmp++;
      if (strobes != 0) begin
        n_fail++;
        $display("FAIL reserved_count cks=%0d: got %0d want 0", sel[s], strobes);
      end
      n_cmp++;
      if (pre_bad != 0) begin
        n_fail++;
        $display("FAIL reserved_wrap cks=%0d: got %0d bad values want 0", sel[s], pre_bad);
      end
    end
  endtask

  // Asynchronous reset clears cnt_en without waiting for a pclk edge.
  task automatic test_async_reset;
    tmr_en = 1'b1;
    cks    = 3'd0;
    do_reset();
    step();
    step();
    n_cmp++;
    if (cnt_en !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre: got %b want 1", cnt_en);
    end
    #2 presetn = 1'b0;
    #1;
    n_cmp++;
    if (cnt_en !== 1'b0) begin
      n_fail++;
      $display("FAIL async_cnt_en: got %b want 0", cnt_en);
    end
    n_cmp++;
    if (pre_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL async_pre_cnt: got %0d want 0", pre_cnt);
    end
    step();
    presetn = 1'b1;
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    presetn = 1'b0;
    tmr_en  = 1'b0;
    cks     = 3'd0;
    ext_clk = 1'b0;
    test_reset();
    test_divide();
    test_pause();
    test_enable_edge();
    test_reselect();
    test_external();
    test_reserved();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
